// File: rtl/conv_window_sched_if.sv
// Pixel stream, window and result bus between conv_window_sched and its neighbours.
// The scheduler uses the slave modport; the pixel source / conv unit side uses master.
interface conv_window_sched_if #(
    parameter int WIDTH = 9,
    parameter int CW    = 7
);
    logic               pix_valid;
    logic               pix_ready;
    logic [WIDTH-1:0]   pix_data;
    logic [9*WIDTH-1:0] win_data;
    logic               win_valid;
    logic [WIDTH-1:0]   conv_out;
    logic               res_valid;
    logic [WIDTH-1:0]   res_data;
    logic [CW-1:0]      res_col;
    logic [CW-1:0]      res_row;

    modport master (
        output pix_valid, pix_data, conv_out,
        input  pix_ready, win_data, win_valid, res_valid, res_data, res_col, res_row
    );

    modport slave (
        input  pix_valid, pix_data, conv_out,
        output pix_ready, win_data, win_valid, res_valid, res_data, res_col, res_row
    );
endinterface

// File: rtl/conv_window_sched.sv
// 3x3 window builder and result tagger for one convolution frame: two line buffers,
// a 3x3 register window, and a latency-matched tag pipe for the conv unit results.
module conv_window_sched #(
    parameter int WIDTH    = 9,
    parameter int MAX_W    = 64,
    parameter int CW       = 7,
    parameter int CONV_LAT = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [CW-1:0] cfg_w,
    input  logic [CW-1:0] cfg_h,
    output logic          busy,
    output logic          done,
    output logic          err_cfg,
    conv_window_sched_if.slave bus
);
    localparam int AW = (MAX_W > 1) ? $clog2(MAX_W) : 1;
    localparam logic [CW:0] MAX_W_C = (CW+1)'(MAX_W);

    typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] w_q, h_q, row, col;
    logic [3:0]    drain_cnt;
    logic          cfg_ok, start_ok, accept, col_wrap, last_pix, win_now;
    logic [AW-1:0] lb_addr;

    logic [WIDTH-1:0] lb0 [MAX_W];
    logic [WIDTH-1:0] lb1 [MAX_W];

    logic [2:0][2:0][WIDTH-1:0]    win_q;
    logic [CONV_LAT:0]             vld_pipe;
    logic [CONV_LAT:0][CW-1:0]     row_pipe;
    logic [CONV_LAT:0][CW-1:0]     col_pipe;

    assign cfg_ok   = (cfg_w >= CW'(3)) && ({1'b0, cfg_w} <= MAX_W_C) && (cfg_h >= CW'(3));
    assign start_ok = (state == IDLE) && start && cfg_ok;
    assign accept   = bus.pix_valid && bus.pix_ready;
    assign col_wrap = (col == w_q - CW'(1));
    assign last_pix = col_wrap && (row == h_q - CW'(1));
    assign win_now  = accept && (row >= CW'(2)) && (col >= CW'(2));
    assign lb_addr  = col[AW-1:0];

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (rst_n) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_ok) state_nxt = LOAD;
            LOAD:    if (accept && last_pix) state_nxt = DRAIN;
            DRAIN:   if (drain_cnt == 4'(CONV_LAT)) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy          = (state == LOAD) || (state == DRAIN);
        done          = (state == DONE);
        bus.pix_ready = (state == LOAD);
    end

    // ---------------- counters and config ----------------
    always_ff @(posedge clk) begin
        if (rst_n) begin
            w_q       <= '0;
            h_q       <= '0;
            row       <= '0;
            col       <= '0;
            drain_cnt <= '0;
            err_cfg   <= 1'b0;
        end else begin
            err_cfg   <= (state == IDLE) && start && !cfg_ok;
            drain_cnt <= (state == DRAIN) ? drain_cnt + 4'd1 : 4'd0;
            if (start_ok) begin
                w_q <= cfg_w;
                h_q <= cfg_h;
                row <= '0;
                col <= '0;
            end else if (accept) begin
                if (col_wrap) begin
                    col <= '0;
                    row <= row + CW'(1);
                end else begin
                    col <= col + CW'(1);
                end
            end
        end
    end

    // Line buffers: lb1 holds row-2, lb0 holds row-1; both read before write.
    always_ff @(posedge clk) begin
        if (accept) begin
            lb0[lb_addr] <= bus.pix_data;
            lb1[lb_addr] <= lb0[lb_addr];
        end
    end

    // ---------------- window ----------------
    always_ff @(posedge clk) begin
        if (rst_n) begin
            win_q <= '0;
        end else if (accept) begin
            for (int r = 0; r < 3; r++) begin
                win_q[r][0] <= win_q[r][1];
                win_q[r][1] <= win_q[r][2];
            end
            win_q[0][2] <= lb1[lb_addr];
            win_q[1][2] <= lb0[lb_addr];
            win_q[2][2] <= bus.pix_data;
        end
    end

    assign bus.win_data  = win_q;
    assign bus.win_valid = vld_pipe[0];

    // Stage 0 is the window itself; stages 1..CONV_LAT track it through the conv unit.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            vld_pipe <= '0;
            row_pipe <= '0;
            col_pipe <= '0;
        end else begin
            vld_pipe <= {vld_pipe[CONV_LAT-1:0], win_now};
            row_pipe <= {row_pipe[CONV_LAT-1:0], row - CW'(2)};
            col_pipe <= {col_pipe[CONV_LAT-1:0], col - CW'(2)};
        end
    end

    // ---------------- results ----------------
    always_ff @(posedge clk) begin
        if (rst_n) begin
            bus.res_valid <= 1'b0;
            bus.res_data  <= '0;
            bus.res_row   <= '0;
            bus.res_col   <= '0;
        end else begin
            bus.res_valid <= vld_pipe[CONV_LAT];
            bus.res_data  <= bus.conv_out;
            bus.res_row   <= row_pipe[CONV_LAT];
            bus.res_col   <= col_pipe[CONV_LAT];
        end
    end
endmodule

// File: tb/tb_conv_window_sched.sv
// Bench for conv_window_sched: two instances (CONV_LAT 2 and 1) share stimulus; observed
// windows/results are compared against a frame-level model built from the pixel list.
module tb_conv_window_sched;
    localparam int W  = 9;
    localparam int CW = 7;

    typedef struct { int cyc; logic [9*W-1:0] data; } win_ev_t;
    typedef struct { int cyc; int row; int col; logic [W-1:0] data; } res_ev_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          start = 1'b0;
    logic [CW-1:0] cfg_w = '0, cfg_h = '0;
    logic          pix_valid = 1'b0;
    logic [W-1:0]  pix_data = '0, conv_out = '0;
    logic          busy2, done2, err2, busy1, done1, err1;
    int            cyc = 0;
    int            checks = 0, errors = 0;

    win_ev_t      win2_q[$], win1_q[$], exp_win[$];
    res_ev_t      res2_q[$], res1_q[$], exp_res2[$], exp_res1[$];
    int           done2_q[$], done1_q[$], exp_done2[$], exp_done1[$];
    logic [1:0]   doneb2_q[$];
    logic [W-1:0] pix_q[$];
    int           acc_q[$];
    logic         prev_busy2 = 1'b0;

    conv_window_sched_if #(.WIDTH(W), .CW(CW)) bus2();
    conv_window_sched_if #(.WIDTH(W), .CW(CW)) bus1();

    assign bus2.pix_valid = pix_valid;
    assign bus2.pix_data  = pix_data;
    assign bus2.conv_out  = conv_out;
    assign bus1.pix_valid = pix_valid;
    assign bus1.pix_data  = pix_data;
    assign bus1.conv_out  = conv_out;

    conv_window_sched #(.WIDTH(W), .MAX_W(64), .CW(CW), .CONV_LAT(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start), .cfg_w(cfg_w), .cfg_h(cfg_h),
        .busy(busy2), .done(done2), .err_cfg(err2), .bus(bus2));

    conv_window_sched #(.WIDTH(W), .MAX_W(64), .CW(CW), .CONV_LAT(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .cfg_w(cfg_w), .cfg_h(cfg_h),
        .busy(busy1), .done(done1), .err_cfg(err1), .bus(bus1));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // conv unit stand-in: result is simply the cycle number it was presented in
    always @(negedge clk) conv_out = W'(cyc);

    always @(negedge clk) begin
        if (bus2.win_valid) win2_q.push_back('{cyc, bus2.win_data});
        if (bus1.win_valid) win1_q.push_back('{cyc, bus1.win_data});
        if (bus2.res_valid) res2_q.push_back('{cyc, int'(bus2.res_row), int'(bus2.res_col), bus2.res_data});
        if (bus1.res_valid) res1_q.push_back('{cyc, int'(bus1.res_row), int'(bus1.res_col), bus1.res_data});
        if (done2) begin done2_q.push_back(cyc); doneb2_q.push_back({prev_busy2, busy2}); end
        if (done1) done1_q.push_back(cyc);
        prev_busy2 = busy2;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

    task automatic clear_all();
        win2_q.delete(); win1_q.delete(); res2_q.delete(); res1_q.delete();
        done2_q.delete(); done1_q.delete(); doneb2_q.delete();
        exp_win.delete(); exp_res2.delete(); exp_res1.delete();
        exp_done2.delete(); exp_done1.delete();
    endtask

    // mode 0: continuous, 1: valid toggles 1/0, 2: random gaps
    task automatic drive_frame(input int w, input int h, input int mode, input bit seq, input bit poke);
        int n, k;
        bit v;
        logic [W-1:0] d;
        pix_q.delete(); acc_q.delete();
        @(negedge clk); start = 1'b1; cfg_w = CW'(w); cfg_h = CW'(h);
        @(negedge clk); start = 1'b0;
        n = 0; k = 0;
        while (n < w*h) begin
            v = (mode == 0) ? 1'b1 : (mode == 1) ? (k % 2 == 0) : ($urandom_range(0, 3) != 0);
            start = poke && (k == 5);
            pix_valid = v;
            d = seq ? W'(n + 1) : W'($urandom);
            pix_data = v ? d : W'($urandom);
            if (v) begin pix_q.push_back(d); acc_q.push_back(cyc + 1); n++; end
            k++;
            @(negedge clk);
        end
        pix_valid = 1'b0; start = 1'b0;
    endtask

    // Reference: every valid-padding window in raster order, seen the cycle after the
    // accept of its bottom-right pixel; result L+1 cycles later carries conv_out of cycle +L.
    task automatic model_frame(input int w, input int h);
        logic [9*W-1:0] dd;
        int a;
        for (int r = 2; r < h; r++)
            for (int c = 2; c < w; c++) begin
                a = acc_q[r*w + c];
                for (int i = 0; i < 3; i++)
                    for (int j = 0; j < 3; j++)
                        dd[(i*3+j)*W +: W] = pix_q[(r-2+i)*w + (c-2+j)];
                exp_win.push_back('{a, dd});
                exp_res2.push_back('{a + 3, r - 2, c - 2, W'(a + 2)});
                exp_res1.push_back('{a + 2, r - 2, c - 2, W'(a + 1)});
            end
        exp_done2.push_back(acc_q[w*h-1] + 3);
        exp_done1.push_back(acc_q[w*h-1] + 2);
    endtask

    task automatic wait_done(input int n);
        for (int k = 0; k < 400 && done2_q.size() < n; k++) @(negedge clk);
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy2, done2, err2, bus2.pix_ready, bus2.win_valid, bus2.win_data, bus2.res_valid,
             bus2.res_data, bus2.res_row, bus2.res_col} !== '0) begin
            errors++; $display("FAIL reset_outs lat2 got nonzero outputs busy=%b win=%h res=%h", busy2, bus2.win_data, bus2.res_data);
        end
        checks++;
        if ({busy1, done1, err1, bus1.pix_ready, bus1.win_valid, bus1.res_valid, bus1.res_data} !== '0) begin
            errors++; $display("FAIL reset_outs lat1 got nonzero outputs busy=%b res=%h", busy1, bus1.res_data);
        end
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (bus2.pix_ready !== 1'b0 || busy2 !== 1'b0) begin
            errors++; $display("FAIL reset_idle got ready=%b busy=%b exp 0 0", bus2.pix_ready, busy2);
        end
    endtask

    task automatic test_bad_cfg();
        int bw[4] = '{2, 65, 4, 5};
        int bh[4] = '{4, 4, 2, 0};
        for (int t = 0; t < 4; t++) begin
            @(negedge clk); start = 1'b1; cfg_w = CW'(bw[t]); cfg_h = CW'(bh[t]);
            @(negedge clk); start = 1'b0;
            checks++;
            if (err2 !== 1'b1 || busy2 !== 1'b0 || bus2.pix_ready !== 1'b0) begin
                errors++; $display("FAIL bad_cfg[%0d] got err=%b busy=%b ready=%b exp 1 0 0", t, err2, busy2, bus2.pix_ready);
            end
            @(negedge clk);
            checks++;
            if (err2 !== 1'b0 || bus2.pix_ready !== 1'b0) begin
                errors++; $display("FAIL bad_cfg_pulse[%0d] got err=%b ready=%b exp 0 0", t, err2, bus2.pix_ready);
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        clear_all();
        @(negedge clk); start = 1'b1; cfg_w = CW'(4); cfg_h = CW'(4);
        @(negedge clk); start = 1'b0;
        for (int n = 0; n < 7; n++) begin
            pix_valid = 1'b1; pix_data = W'(n + 1);
            @(negedge clk);
        end
        pix_valid = 1'b0; rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({busy2, done2, err2, bus2.pix_ready, bus2.win_valid, bus2.win_data, bus2.res_valid,
             bus2.res_data, bus2.res_row, bus2.res_col} !== '0) begin
            errors++; $display("FAIL midreset_outs got busy=%b ready=%b win=%h exp all 0", busy2, bus2.pix_ready, bus2.win_data);
        end
        rst_n = 1'b0;
        repeat (10) @(negedge clk);
        checks++;
        if (done2_q.size() != 0 || win2_q.size() != 0 || res2_q.size() != 0 || bus2.pix_ready !== 1'b0) begin
            errors++; $display("FAIL midreset_after got done=%0d win=%0d res=%0d ready=%b exp 0 0 0 0",
                               done2_q.size(), win2_q.size(), res2_q.size(), bus2.pix_ready);
        end
    endtask

    task automatic test_frames();
        int tw[8] = '{4, 4, 3, 5, 64, 0, 0, 0};
        int th[8] = '{4, 4, 3, 4, 3, 0, 0, 0};
        int tm[8] = '{0, 1, 0, 0, 2, 2, 2, 2};
        bit ts[8] = '{1, 1, 1, 0, 0, 0, 0, 0};
        int w, h;
        win_ev_t ow[$];
        res_ev_t orr[$], er[$];
        int od[$], ed[$];
        logic [9*W-1:0] first4;
        for (int t = 0; t < 8; t++) begin
            w = tw[t]; h = th[t];
            if (t >= 5) begin w = $urandom_range(3, 12); h = $urandom_range(3, 6); end
            clear_all();
            drive_frame(w, h, tm[t], ts[t], 1'b0);
            model_frame(w, h);
            wait_done(1);
            for (int d = 0; d < 2; d++) begin
                if (d == 0) begin ow = win2_q; orr = res2_q; od = done2_q; er = exp_res2; ed = exp_done2; end
                else        begin ow = win1_q; orr = res1_q; od = done1_q; er = exp_res1; ed = exp_done1; end
                checks++;
                if (ow.size() != exp_win.size()) begin
                    errors++; $display("FAIL frame%0d d%0d win_count got %0d exp %0d", t, d, ow.size(), exp_win.size());
                end
                for (int i = 0; i < ow.size() && i < exp_win.size(); i++) begin
                    checks++;
                    if (ow[i].cyc != exp_win[i].cyc || ow[i].data !== exp_win[i].data) begin
                        errors++; $display("FAIL frame%0d d%0d win[%0d] got cyc=%0d data=%h exp cyc=%0d data=%h",
                                           t, d, i, ow[i].cyc, ow[i].data, exp_win[i].cyc, exp_win[i].data);
                    end
                end
                checks++;
                if (orr.size() != er.size()) begin
                    errors++; $display("FAIL frame%0d d%0d res_count got %0d exp %0d", t, d, orr.size(), er.size());
                end
                for (int i = 0; i < orr.size() && i < er.size(); i++) begin
                    checks++;
                    if (orr[i].cyc != er[i].cyc || orr[i].row != er[i].row || orr[i].col != er[i].col || orr[i].data !== er[i].data) begin
                        errors++; $display("FAIL frame%0d d%0d res[%0d] got cyc=%0d r=%0d c=%0d data=%h exp cyc=%0d r=%0d c=%0d data=%h",
                                           t, d, i, orr[i].cyc, orr[i].row, orr[i].col, orr[i].data,
                                           er[i].cyc, er[i].row, er[i].col, er[i].data);
                    end
                end
                checks++;
                if (od.size() != 1 || od[0] != ed[0]) begin
                    errors++; $display("FAIL frame%0d d%0d done got count=%0d cyc=%0d exp count=1 cyc=%0d",
                                       t, d, od.size(), (od.size() > 0) ? od[0] : -1, ed[0]);
                end
            end
            checks++;
            if (doneb2_q.size() != 1 || doneb2_q[0] !== 2'b10) begin
                errors++; $display("FAIL frame%0d busy_at_done got %0d events first=%b exp 1 event 10", t,
                                   doneb2_q.size(), (doneb2_q.size() > 0) ? doneb2_q[0] : 2'bxx);
            end
            if (t == 0) begin
                first4 = {9'd11, 9'd10, 9'd9, 9'd7, 9'd6, 9'd5, 9'd3, 9'd2, 9'd1};
                checks++;
                if (win2_q.size() != 4 || win2_q[0].data !== first4 || win2_q[3].data[9*W-1 -: W] !== 9'd16) begin
                    errors++; $display("FAIL first_window_4x4 got n=%0d first=%h exp n=4 first=%h last_a22=16",
                                       win2_q.size(), (win2_q.size() > 0) ? win2_q[0].data : '0, first4);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        int dstart;
        clear_all();
        drive_frame(4, 4, 0, 1'b1, 1'b1);
        model_frame(4, 4);
        dstart = acc_q[acc_q.size()-1] + 3;
        for (int k = 0; k < 50 && cyc < dstart; k++) @(negedge clk);
        drive_frame(4, 4, 2, 1'b0, 1'b0);
        model_frame(4, 4);
        wait_done(2);
        checks++;
        if (win2_q.size() != exp_win.size() || res2_q.size() != exp_res2.size()) begin
            errors++; $display("FAIL b2b_counts got win=%0d res=%0d exp win=%0d res=%0d",
                               win2_q.size(), res2_q.size(), exp_win.size(), exp_res2.size());
        end
        for (int i = 0; i < win2_q.size() && i < exp_win.size(); i++) begin
            checks++;
            if (win2_q[i].cyc != exp_win[i].cyc || win2_q[i].data !== exp_win[i].data) begin
                errors++; $display("FAIL b2b_win[%0d] got cyc=%0d data=%h exp cyc=%0d data=%h",
                                   i, win2_q[i].cyc, win2_q[i].data, exp_win[i].cyc, exp_win[i].data);
            end
        end
        for (int i = 0; i < res2_q.size() && i < exp_res2.size(); i++) begin
            checks++;
            if (res2_q[i].cyc != exp_res2[i].cyc || res2_q[i].row != exp_res2[i].row ||
                res2_q[i].col != exp_res2[i].col || res2_q[i].data !== exp_res2[i].data) begin
                errors++; $display("FAIL b2b_res[%0d] got cyc=%0d r=%0d c=%0d exp cyc=%0d r=%0d c=%0d",
                                   i, res2_q[i].cyc, res2_q[i].row, res2_q[i].col,
                                   exp_res2[i].cyc, exp_res2[i].row, exp_res2[i].col);
            end
        end
        checks++;
        if (done2_q.size() != 2 || done2_q[0] != exp_done2[0] || done2_q[1] != exp_done2[1]) begin
            errors++; $display("FAIL b2b_done got count=%0d exp count=2 cyc=%0d,%0d", done2_q.size(), exp_done2[0], exp_done2[1]);
        end
        checks++;
        if (win2_q.size() < 5 || win2_q[4].data[W-1:0] !== pix_q[0]) begin
            errors++; $display("FAIL b2b_a00 got n=%0d a00=%h exp a00=%h", win2_q.size(),
                               (win2_q.size() > 4) ? win2_q[4].data[W-1:0] : '0, pix_q[0]);
        end
    endtask

    initial begin
        test_reset();
        test_bad_cfg();
        test_reset_mid_frame();
        test_frames();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/conv_window_sched.md
Name: conv_window_sched

Overview:
- Sequences the 3x3 convolution datapath over one image frame.
- Accepts a raster pixel stream and builds 3x3 windows with two line buffers and a 3x3 register array.
- Presents each valid window (valid padding, stride 1) to the conv unit, then tags the conv unit's result with output row/col after the conv unit's fixed latency.
- Provides frame start, busy and done control to the layer sequencer.

Parameters:
- WIDTH, 9: pixel, weight and result width; matches the conv unit.
- MAX_W, 64: maximum image width; line buffer depth.
- CW, 7: width of the cfg_w, cfg_h, res_col and res_row fields.
- CONV_LAT, 2: conv unit pipeline latency in cycles; legal range 1..15.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; synchronous, active-high (port name kept per codebase convention)
- start  in  1  one-cycle frame start; sampled only in IDLE
- cfg_w  in  CW  image width; latched on accepted start
- cfg_h  in  CW  image height; latched on accepted start
- busy  out  1  high in LOAD and DRAIN
- done  out  1  one-cycle pulse at end of frame
- err_cfg  out  1  one-cycle pulse when start is rejected for illegal cfg
- pix_valid  in  1  input pixel valid
- pix_ready  out  1  input pixel ready
- pix_data  in  WIDTH  input pixel, raster order
- win_data  out  9*WIDTH  window, packed a00 at [WIDTH-1:0] ... a22 at MSB; row-major a00,a01,a02,a10,...,a22
- win_valid  out  1  win_data holds a new window this cycle
- conv_out  in  WIDTH  conv unit result
- res_valid  out  1  res_data valid
- res_data  out  WIDTH  registered copy of conv_out
- res_col  out  CW  output column of res_data
- res_row  out  CW  output row of res_data

Behaviour:
- Reset: state IDLE. All outputs 0: pix_ready, win_valid, win_data, res_valid, res_data, res_col, res_row, busy, done, err_cfg. Row/col counters and the latency shift register are cleared. Line buffer RAM is not cleared; its contents are don't-care.
- FSM states: IDLE, LOAD, DRAIN, DONE.
- IDLE -> LOAD:
  - Transition on start with 3<=cfg_w<=MAX_W and cfg_h>=3.
  - Latch cfg_w and cfg_h; clear row and col to 0.
- IDLE, illegal cfg: on start with illegal cfg, err_cfg pulses the next cycle and the state stays IDLE.
- start outside IDLE is ignored; no error is flagged.
- LOAD:
  - pix_ready = 1.
  - Accept occurs on pix_valid & pix_ready.
  - On each accept:
    - Window columns shift left; the new right column is {lb1[col], lb0[col], pix_data}.
    - lb1[col] <= lb0[col] and lb0[col] <= pix_data (read-before-write).
    - col increments; at col == cfg_w-1 it wraps to 0 and row increments.
  - No accept means no state change; gaps in pix_valid are legal.
- Window (a22 = pixel at (row, col), a00 = pixel at (row-2, col-2)):
  - win_valid is registered: high the cycle after an accept with row>=2 and col>=2, otherwise 0.
  - win_data holds its value between windows.
  - Expected window count is (cfg_w-2)*(cfg_h-2).
- LOAD -> DRAIN: on accept of pixel (cfg_h-1, cfg_w-1). pix_ready drops the next cycle.
- DRAIN:
  - Wait CONV_LAT+1 cycles so that the last window's result has been emitted.
  - Then move to DONE.
- DONE: done = 1 for one cycle, then IDLE. busy is 0 in DONE.
- Result tagging:
  - A CONV_LAT-deep shift register carries {win_valid, row-2, col-2}.
  - res_valid, res_row and res_col are registered from the shift register tail.
  - res_data is registered from conv_out.
  - Total result latency is CONV_LAT+1 cycles after win_valid.
  - There is no output backpressure; the consumer must accept every res_valid.
- Back-to-back frames: start is accepted in the cycle after done. New-frame windows never use stale line data, because win_valid requires row>=2.
- Reset mid-frame:
  - Returns to IDLE the next cycle.
  - In-flight results are discarded; res_valid = 0 from the cycle after reset.
  - No done pulse is issued.
- Width rules:
  - row and col are CW bits.
  - res_row and res_col are in the range 0..cfg_h-3 and 0..cfg_w-3.
  - No arithmetic is applied to pixel data.

Test Plan:
- 4x4 frame, pixels 1..16 continuous, CONV_LAT=2 -> exactly 4 win_valid. First window is a00..a22 = 1,2,3,5,6,7,9,10,11. Last window a22 = 16. res (row,col) sequence is (0,0),(0,1),(1,0),(1,1); each res appears 3 cycles after its win_valid. done pulses once; busy falls with done.
- Same frame with pix_valid toggling 1/0 every cycle -> identical window contents and order; windows appear only after accepts.
- start with cfg_w=2 -> err_cfg pulse, state stays IDLE, pix_ready=0. start with cfg_w=MAX_W+1 gives the same result. start with cfg_w=3, cfg_h=3 -> exactly 1 window (pixels 1..9).
- rst_n asserted after 7 pixels of a 4x4 frame -> next cycle all outputs 0, no done pulse. A following full frame produces correct windows.
- start pulsed during LOAD -> ignored, frame completes normally. Second start the cycle after done -> second frame correct, with first-window a00 taken from the new frame.
- 5x4 frame with CONV_LAT=1 and conv_out driven as a per-cycle counter -> res_data equals the conv_out value sampled 1 cycle after each win_valid; 6 results total.
